shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl.sv | 125 ++++++++++++
 tb/tb_shift_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ctrl.sv
// Request/response sequencer for an external combinational funnel shifter.
// Optional zero-shift bypass enabled by defining SHIFT_CTRL_ZERO_FAST_EN.
module shift_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_shamt,
  output logic [31:0] sh_h,
  output logic [31:0] sh_l,
  output logic [4:0]  sh_shamt,
  output logic        sh_reverse,
  input  logic [31:0] sh_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
    logic        rev;
    logic        ill;
  } dec_t;

  state_t state;
  dec_t   dec;
  logic   fast;

  always_comb begin
    dec     = '0;
    dec.l   = req_a;
    unique case (req_op)
      4'd0: dec.h = '0;
      4'd1: dec.h = {32{req_a[31]}};
      4'd2: dec.rev = 1'b1;
      4'd3: dec.h = '1;
      4'd4: begin
        dec.h   = '1;
        dec.rev = 1'b1;
      end
      4'd5: dec.h = req_a;
      4'd6: begin
        dec.h   = req_a;
        dec.rev = 1'b1;
      end
      4'd7: dec.h = req_b;
      4'd8: begin
        dec.h   = req_b;
        dec.rev = 1'b1;
      end
      default: begin
        dec.l   = '0;
        dec.ill = 1'b1;
      end
    endcase
  end

`ifdef SHIFT_CTRL_ZERO_FAST_EN
  assign fast = !dec.ill && (req_shamt == 5'd0);
`else
  assign fast = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sh_h       <= '0;
      sh_l       <= '0;
      sh_shamt   <= '0;
      sh_reverse <= 1'b0;
      rsp_y      <= '0;
      rsp_err    <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            sh_h       <= dec.h;
            sh_l       <= dec.l;
            sh_shamt   <= req_shamt;
            sh_reverse <= dec.rev;
            rsp_err    <= dec.ill;
            if (fast) begin
              rsp_y     <= req_a;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // illegal ops force a zero result regardless of the shifter
          rsp_y     <= rsp_err ? 32'd0 : sh_y;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl with a behavioural funnel shifter
// and an arithmetic reference model of every operation.
module tb_shift_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_shamt = '0;
  logic [31:0] sh_h, sh_l, sh_y;
  logic [4:0]  sh_shamt;
  logic        sh_reverse;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_y;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  shift_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_shamt(req_shamt),
    .sh_h(sh_h), .sh_l(sh_l), .sh_shamt(sh_shamt),
    .sh_reverse(sh_reverse), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // external funnel shifter: right takes low word of {H,L}>>s,
  // left takes high word of {L,H}<<s
  logic [63:0] fr, fl;
  assign fr = {sh_h, sh_l} >> sh_shamt;
  assign fl = {sh_l, sh_h} << sh_shamt;
  assign sh_y = sh_reverse ? fl[63:32] : fr[31:0];

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int s);
    logic [31:0] r;
    case (op)
      4'd0: r = a >> s;
      4'd1: r = $signed(a) >>> s;
      4'd2: r = a << s;
      4'd3: r = ~((~a) >> s);
      4'd4: r = ~((~a) << s);
      4'd5: r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      4'd6: r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4'd7: r = (s == 0) ? a : ((a >> s) | (b << (32 - s)));
      4'd8: r = (s == 0) ? a : ((a << s) | (b >> (32 - s)));
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // entered and left at posedge+1 with the DUT in IDLE
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s,
                        input int hold, input logic [31:0] ey,
                        input logic ee, input string nm);
    int lat;
    int elat;
    logic legal;
    logic [31:0] eh, el;
    logic er;
    legal = (op < 4'd9);
    case (op)
      4'd1: eh = {32{a[31]}};
      4'd3, 4'd4: eh = 32'hFFFF_FFFF;
      4'd5, 4'd6: eh = a;
      4'd7, 4'd8: eh = b;
      default: eh = 32'd0;
    endcase
    el = legal ? a : 32'd0;
    er = (op == 4'd2) || (op == 4'd4) || (op == 4'd6) || (op == 4'd8);
    elat = 2;
`ifdef SHIFT_CTRL_ZERO_FAST_EN
    if (legal && s == 5'd0) elat = 1;
`endif
    chk({nm, " req_ready idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_shamt = s;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({nm, " sh_h"}, 64'(sh_h), 64'(eh));
    chk({nm, " sh_l"}, 64'(sh_l), 64'(el));
    chk({nm, " sh_reverse"}, 64'(sh_reverse), 64'(er));
    if (legal) chk({nm, " sh_shamt"}, 64'(sh_shamt), 64'(s));
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    if (!rsp_valid) return;
    chk({nm, " rsp_y"}, 64'(rsp_y), 64'(ey));
    chk({nm, " rsp_err"}, 64'(rsp_err), 64'(ee));
    chk({nm, " req_ready busy"}, 64'(req_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " hold valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, " hold y"}, 64'(rsp_y), 64'(ey));
      chk({nm, " hold err"}, 64'(rsp_err), 64'(ee));
      chk({nm, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, " done valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, " done req_ready"}, 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic [31:0] y;
    logic        err;
    string       nm;
  } vec_t;

  vec_t vt[8];

  initial begin
    int acc;
    int ovl;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [4:0] s;

    vt[0] = '{4'd1, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 1'b0, "sra"};
    vt[1] = '{4'd6, 32'h8000_0001, 32'h0, 5'd1, 32'h0000_0003, 1'b0, "rol"};
    vt[2] = '{4'd8, 32'h0000_0001, 32'h8000_0000, 5'd1, 32'h0000_0003, 1'b0, "fsl"};
    vt[3] = '{4'd7, 32'h0, 32'h0000_0001, 5'd1, 32'h8000_0000, 1'b0, "fsr"};
    vt[4] = '{4'd4, 32'h0, 32'h0, 5'd4, 32'h0000_000F, 1'b0, "slo"};
    vt[5] = '{4'd12, 32'hFFFF_FFFF, 32'h1234, 5'd3, 32'h0, 1'b1, "illegal"};
    vt[6] = '{4'd0, 32'hDEAD_BEEF, 32'h0, 5'd0, 32'hDEAD_BEEF, 1'b0, "srl0"};
    vt[7] = '{4'd3, 32'h0000_0100, 32'h0, 5'd8, 32'hFF00_0001, 1'b0, "sro"};

    #12;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_y", 64'(rsp_y), 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    chk("reset sh_h", 64'(sh_h), 64'd0);
    chk("reset sh_l", 64'(sh_l), 64'd0);
    chk("reset sh_shamt", 64'(sh_shamt), 64'd0);
    chk("reset sh_reverse", 64'(sh_reverse), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset req_ready", 64'(req_ready), 64'd1);

    foreach (vt[i])
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].s, 0,
             vt[i].y, vt[i].err, vt[i].nm);

    run_op(4'd5, 32'h1234_5678, 32'h0, 5'd8, 3,
           32'h7812_3456, 1'b0, "ror stall");

    // reset pulsed while the operation sits in ISSUE
    req_valid = 1'b1;
    req_op = 4'd7;
    req_a = 32'h1234_5678;
    req_b = 32'hCAFE_F00D;
    req_shamt = 5'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid reset rsp_y", 64'(rsp_y), 64'd0);
    chk("mid reset sh_h", 64'(sh_h), 64'd0);
    chk("mid reset sh_l", 64'(sh_l), 64'd0);
    chk("mid reset sh_shamt", 64'(sh_shamt), 64'd0);
    chk("mid reset rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("discarded rsp_valid", 64'(rsp_valid), 64'd0);
    end
    chk("discarded req_ready", 64'(req_ready), 64'd1);

    // back-to-back requests: one accept every 3 cycles
    acc = 0;
    ovl = 0;
    req_valid = 1'b1;
    req_op = 4'd0;
    req_a = 32'hA5A5_0000;
    req_shamt = 5'd5;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc++;
      if (req_ready && rsp_valid) ovl++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("ii accepts", 64'(acc), 64'd4);
    chk("ii overlap", 64'(ovl), 64'd0);
    chk("ii end idle", 64'(req_ready), 64'd1);

    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      s = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) s = 5'd0;
      run_op(op, a, b, s, int'($urandom_range(0, 2)),
             model(op, a, b, int'(s)), op > 4'd8, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
